mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit. Consumes the EX/MEM pipeline register outputs, drives the data-memory bus with a req/gnt/rvalid handshake, aligns load data and store data, and owns the MEM/WB pipeline register.
- Stalls the upstream pipeline while a memory access is outstanding. Non-memory instructions pass through with one cycle of latency and no stall.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous, active-low
- pc_in  in  32  PC from the EX/MEM register
- alu_result_in  in  32  effective address, or the ALU result for non-memory instructions
- rs2_data_in  in  32  store data
- rd_in  in  5  destination register
- funct3_in  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in  in  1 each  control bits
- stall_o  out  1  holds PC/IF/ID/EX/MEM registers; combinational
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load data
- wb_pc, wb_alu_result, wb_mem_data  out  32 each  MEM/WB register outputs
- wb_rd  out  5  MEM/WB destination register
- wb_reg_write, wb_mem_to_reg  out  1 each  MEM/WB control bits
- misalign_o  out  1  misaligned-access pulse

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; every registered output is cleared to 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, all wb_* outputs, misalign_o.
- Reset mid-access (REQ or RSP): request dropped at that edge. Any later gnt/rvalid is ignored until a new request.
- mem_op = mem_read_in | mem_write_in. If both are set, it is treated as a load.

FSM (states IDLE, REQ, RSP, DONE):
- IDLE: if mem_op and not misaligned, go to REQ. Register dmem_req=1, dmem_we=mem_write_in, addr, wdata, be.
- REQ: dmem_req held, with all bus outputs stable, until dmem_gnt=1.
  - On gnt, a store goes to DONE with dmem_req=0.
  - On gnt, a load goes to RSP with dmem_req=0.
- RSP: wait for dmem_rvalid. Capture the extracted load data into an internal register, then go to DONE.
- DONE: go to IDLE next cycle.
- dmem_rvalid outside RSP is ignored.
- stall_o = mem_op & (state != DONE) & !misaligned. Inputs are therefore held stable for the whole access.
- Minimum load: 3 stall cycles. Minimum store: 2 stall cycles (gnt in the first REQ cycle). No timeout.

MEM/WB register, each edge:
- stall_o=1: insert a bubble (wb_reg_write=0, wb_mem_to_reg=0); other wb_* fields hold.
- Otherwise: load wb_pc, wb_alu_result, wb_rd, wb_reg_write and wb_mem_to_reg from the inputs.
- wb_mem_data takes the captured load data; it holds its previous value for non-load instructions.

Load extraction (byte lane = addr[1:0]):
- B/BU: select byte at addr[1:0]; sign-extend (B) or zero-extend (BU).
- H/HU: select half at addr[1]; sign-extend (H) or zero-extend (HU).
- W: full word.

Store encoding:
- SB: wdata = {4{rs2[7:0]}}; be = 0001 << addr[1:0].
- SH: wdata = {2{rs2[15:0]}}; be = 0011 << {addr[1],1'b0}.
- SW: wdata = rs2; be = 1111.

Misaligned access:
- H/HU/SH with addr[0]=1.
- W/SW with addr[1:0]!=0.
- Handling is defined under Optional Feature.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned access issues no bus access and causes no stall. At the next edge: misalign_o=1 for one cycle, wb_reg_write=0, wb_mem_to_reg=0.
- Undefined: misalign_o is tied 0. Offending low address bits are forced to alignment (half: addr[0]=0; word: addr[1:0]=0), and the access proceeds normally.

Test Plan:
- ADD (reg_write=1, mem_op=0, alu_result=0x1234) -> stall_o=0, no dmem_req; next edge wb_alu_result=0x1234, wb_reg_write=1.
- LB addr=0x103, gnt after 2 wait cycles, rdata=0x80AA_BBCC -> dmem_addr=0x100; wb_mem_data=0xFFFF_FF80; stall_o high for exactly 5 cycles; wb_reg_write=0 throughout the stall, then 1 for one cycle.
- SH addr=0x202, rs2=0xDEAD_BEEF, gnt immediate -> dmem_we=1, be=1100, wdata=0xBEEF_BEEF; 2 stall cycles.
- LHU addr=0x10, gnt immediate, rvalid after 3 RSP cycles, rdata=0x1234_8765 -> wb_mem_data=0x0000_8765; stray rvalid asserted during REQ is ignored.
- Load with rst_n=0 pulsed while in RSP -> state IDLE; dmem_req=0 and all wb_*=0 after that edge; a late rvalid causes no write.
- LW addr=0x6 with LSU_MISALIGN_TRAP_EN -> no dmem_req, stall_o=0, misalign_o=1 for one cycle, wb_reg_write=0. Without the macro -> dmem_addr=0x4, normal load.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit.
// Drives the data-memory req/gnt/rvalid bus and aligns load and store data.
// Owns the MEM/WB pipeline register. Stalls upstream while an access is outstanding.
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
// Without it, offending low address bits are forced to alignment instead.
module mem_stage_lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [XLEN-1:0] rs2_data_in,
    input  logic [4:0]      rd_in,
    input  logic [2:0]      funct3_in,
    input  logic            reg_write_in,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    input  logic            mem_to_reg_in,
    output logic            stall_o,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] wb_pc,
    output logic [XLEN-1:0] wb_alu_result,
    output logic [XLEN-1:0] wb_mem_data,
    output logic [4:0]      wb_rd,
    output logic            wb_reg_write,
    output logic            wb_mem_to_reg,
    output logic            misalign_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2, DONE = 2'd3} state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic              mem_op_s;
    logic              is_load_s;
    logic              trap_s;
    logic              start_s;
    logic [1:0]        lane_s;
    logic [XLEN-1:0]   load_ext_s;
    logic [XLEN-1:0]   load_data_r;

    // Select and sign/zero-extend the addressed byte or half of a bus word.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                                 input logic [31:0] word);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res_v;
        byte_v = word[{lane, 3'b000} +: 8];
        half_v = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res_v = {{24{byte_v[7]}}, byte_v};
            3'b001:  res_v = {{16{half_v[15]}}, half_v};
            3'b100:  res_v = {24'h00_0000, byte_v};
            3'b101:  res_v = {16'h0000, half_v};
            default: res_v = word;
        endcase
        return res_v;
    endfunction

    // Replicate store data across every lane of its size.
    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        logic [31:0] res_v;
        case (f3[1:0])
            2'b00:   res_v = {4{rs2[7:0]}};
            2'b01:   res_v = {2{rs2[15:0]}};
            default: res_v = rs2;
        endcase
        return res_v;
    endfunction

    // Byte enables for the addressed lane(s).
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
        logic [3:0] res_v;
        case (f3[1:0])
            2'b00:   res_v = 4'b0001 << lane;
            2'b01:   res_v = 4'b0011 << {lane[1], 1'b0};
            default: res_v = 4'b1111;
        endcase
        return res_v;
    endfunction

    assign mem_op_s  = mem_read_in | mem_write_in;
    assign is_load_s = mem_read_in;   // read+write together is a load

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned_s;

    // Flag halves on odd addresses and words off a word boundary.
    always_comb begin
        misaligned_s = 1'b0;
        case (funct3_in[1:0])
            2'b01:        misaligned_s = mem_op_s & alu_result_in[0];
            2'b10, 2'b11: misaligned_s = mem_op_s & (|alu_result_in[1:0]);
            default:      misaligned_s = 1'b0;
        endcase
    end

    assign trap_s = misaligned_s;
    assign lane_s = alu_result_in[1:0];
`else
    assign trap_s = 1'b0;

    // Force the low address bits of halves and words down to natural alignment.
    always_comb begin
        lane_s = alu_result_in[1:0];
        case (funct3_in[1:0])
            2'b01:        lane_s = {alu_result_in[1], 1'b0};
            2'b10, 2'b11: lane_s = 2'b00;
            default:      lane_s = alu_result_in[1:0];
        endcase
    end
`endif

    assign start_s    = (state_r == IDLE) & mem_op_s & ~trap_s;
    assign stall_o    = mem_op_s & (state_r != DONE) & ~trap_s;
    assign load_ext_s = load_extract(funct3_in, lane_s, dmem_rdata);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) state_next_s = REQ;
                else         state_next_s = IDLE;
            end
            REQ: begin
                if (dmem_gnt) state_next_s = is_load_s ? RSP : DONE;
                else          state_next_s = REQ;
            end
            RSP: begin
                if (dmem_rvalid) state_next_s = DONE;
                else             state_next_s = RSP;
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Bus outputs: launched on leaving IDLE, held in REQ until granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= 4'b0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= ~is_load_s;
                        dmem_addr  <= {alu_result_in[XLEN-1:2], 2'b00};
                        dmem_wdata <= store_wdata(funct3_in, rs2_data_in);
                        dmem_be    <= store_be(funct3_in, lane_s);
                    end
                end
                REQ: begin
                    if (dmem_gnt) dmem_req <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Capture extracted load data when the response arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_data_r <= '0;
        end else if ((state_r == RSP) && dmem_rvalid) begin
            load_data_r <= load_ext_s;
        end
    end

    // MEM/WB register: bubble while stalled, otherwise advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_pc         <= '0;
            wb_alu_result <= '0;
            wb_mem_data   <= '0;
            wb_rd         <= 5'd0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            misalign_o    <= 1'b0;
        end else begin
            misalign_o <= trap_s;
            if (stall_o) begin
                wb_reg_write  <= 1'b0;
                wb_mem_to_reg <= 1'b0;
            end else begin
                wb_pc         <= pc_in;
                wb_alu_result <= alu_result_in;
                wb_rd         <= rd_in;
                wb_reg_write  <= reg_write_in & ~trap_s;
                wb_mem_to_reg <= mem_to_reg_in & ~trap_s;
                if (is_load_s & ~trap_s) wb_mem_data <= load_data_r;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed table, reset corners, random ops.
module tb_mem_stage_lsu;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_in, alu_result_in, rs2_data_in, dmem_rdata;
    logic [4:0]  rd_in;
    logic [2:0]  funct3_in;
    logic        reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in;
    logic        stall_o, dmem_req, dmem_we, dmem_gnt, dmem_rvalid, misalign_o;
    logic [31:0] dmem_addr, dmem_wdata, wb_pc, wb_alu_result, wb_mem_data;
    logic [3:0]  dmem_be;
    logic [4:0]  wb_rd;
    logic        wb_reg_write, wb_mem_to_reg;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .alu_result_in(alu_result_in),
        .rs2_data_in(rs2_data_in), .rd_in(rd_in), .funct3_in(funct3_in),
        .reg_write_in(reg_write_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_to_reg_in(mem_to_reg_in), .stall_o(stall_o), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_pc(wb_pc), .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .misalign_o(misalign_o)
    );

    typedef struct {
        logic [31:0] pc, alu, rs2, rdata;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        rw, mr, mw, m2r, stray;
        int          gw, rv;
        int          e_stall;
        logic        e_req, e_mis;
        logic [31:0] e_addr, e_wdata, e_mdata;
        logic [3:0]  e_be;
    } vec_t;

    localparam int NTBL = 10;
    vec_t        tbl[NTBL];
    logic [2:0]  ld_f3[5];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mdata_model;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive_nop();
        pc_in = 32'h0; alu_result_in = 32'h0; rs2_data_in = 32'h0; rd_in = 5'd0;
        funct3_in = 3'b000; reg_write_in = 1'b0; mem_read_in = 1'b0;
        mem_write_in = 1'b0; mem_to_reg_in = 1'b0;
    endtask

    // Apply one instruction at posedge+1 and play the memory side until it retires.
    task automatic run_op(input vec_t v);
        int rq_n, rs_n, nst;
        bit granted, delivered, done, saw_req, bubble_ok, is_st, is_ld;
        is_st = v.mw & ~v.mr;
        is_ld = v.mr;
        pc_in = v.pc; alu_result_in = v.alu; rs2_data_in = v.rs2; rd_in = v.rd;
        funct3_in = v.f3; reg_write_in = v.rw; mem_read_in = v.mr;
        mem_write_in = v.mw; mem_to_reg_in = v.m2r;
        rq_n = 0; rs_n = 0; nst = 0;
        granted = 0; delivered = 0; done = 0; saw_req = 0; bubble_ok = 1;
        for (int c = 0; c < 64 && !done; c++) begin
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
            if (dmem_req) begin
                if (!saw_req) begin
                    saw_req = 1;
                    chk("bus_addr", dmem_addr, v.e_addr);
                    chk("bus_we", 32'(dmem_we), 32'(is_st));
                    if (is_st) begin
                        chk("bus_be", 32'(dmem_be), 32'(v.e_be));
                        chk("bus_wdata", dmem_wdata, v.e_wdata);
                    end
                end
                dmem_gnt = (rq_n >= v.gw);
                rq_n++;
                dmem_rvalid = v.stray;
                dmem_rdata = ~v.rdata;
                if (dmem_gnt && is_ld) granted = 1;
            end else if (granted) begin
                if (!delivered) begin
                    dmem_rdata = v.rdata;
                    dmem_rvalid = (rs_n >= v.rv);
                    rs_n++;
                    if (dmem_rvalid) delivered = 1;
                end else begin
                    dmem_rdata = ~v.rdata;
                    dmem_rvalid = 1'b1;
                end
            end
            #1;
            if (stall_o) nst++;
            else done = 1;
            @(posedge clk); #1;
            if (!done && wb_reg_write) bubble_ok = 0;
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        chk("retired", 32'(done), 32'd1);
        chk("stall_cycles", 32'(nst), 32'(v.e_stall));
        chk("bus_req_seen", 32'(saw_req), 32'(v.e_req));
        chk("bubble", 32'(bubble_ok), 32'd1);
        chk("req_idle", 32'(dmem_req), 32'd0);
        chk("wb_pc", wb_pc, v.pc);
        chk("wb_alu", wb_alu_result, v.alu);
        chk("wb_rd", 32'(wb_rd), 32'(v.rd));
        chk("wb_reg_write", 32'(wb_reg_write), 32'(v.rw & ~v.e_mis));
        chk("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(v.m2r & ~v.e_mis));
        chk("wb_mem_data", wb_mem_data, v.e_mdata);
        chk("misalign", 32'(misalign_o), 32'(v.e_mis));
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_req"}, 32'(dmem_req), 32'd0);
        chk({tag, "_addr"}, dmem_addr, 32'd0);
        chk({tag, "_wb_pc"}, wb_pc, 32'd0);
        chk({tag, "_wb_alu"}, wb_alu_result, 32'd0);
        chk({tag, "_wb_mdata"}, wb_mem_data, 32'd0);
        chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
        chk({tag, "_wb_rw"}, 32'(wb_reg_write), 32'd0);
        chk({tag, "_wb_m2r"}, 32'(wb_mem_to_reg), 32'd0);
        chk({tag, "_mis"}, 32'(misalign_o), 32'd0);
    endtask

    // Reset pulsed mid-load (in REQ, or in RSP), then a late gnt/rvalid.
    task automatic reset_mid(input bit in_rsp);
        pc_in = 32'h3000; alu_result_in = 32'h300; rs2_data_in = 32'h0; rd_in = 5'd5;
        funct3_in = 3'b010; reg_write_in = 1'b1; mem_read_in = 1'b1;
        mem_write_in = 1'b0; mem_to_reg_in = 1'b1;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_req_up", 32'(dmem_req), 32'd1);
        if (in_rsp) begin
            dmem_gnt = 1'b1;
            @(posedge clk); #1;
            dmem_gnt = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_cleared(in_rsp ? "rst_rsp" : "rst_req");
        rst_n = 1'b1;
        drive_nop();
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_DEAD;
        #1;
        chk("late_stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        chk("late_req", 32'(dmem_req), 32'd0);
        chk("late_wb_rw", 32'(wb_reg_write), 32'd0);
        chk("late_wb_mdata", wb_mem_data, 32'd0);
        mdata_model = 32'h0;
    endtask

    // Random instruction with expectations derived from the access rules.
    task automatic rand_op();
        vec_t v;
        int kind, size, off;
        int unsigned lo;
        bit mis, trap;
        logic [31:0] a, mask, val, w;
        kind = $urandom_range(0, 2);
        v.pc = $urandom; v.alu = $urandom; v.rs2 = $urandom; v.rdata = $urandom;
        v.rd = 5'($urandom_range(0, 31));
        v.rw = 1'($urandom_range(0, 1)); v.m2r = 1'($urandom_range(0, 1));
        v.stray = 1'($urandom_range(0, 1));
        v.gw = $urandom_range(0, 3); v.rv = $urandom_range(0, 3);
        v.mr = (kind == 1); v.mw = (kind == 2);
        if (kind == 1) v.f3 = ld_f3[$urandom_range(0, 4)];
        else if (kind == 2) v.f3 = 3'($urandom_range(0, 2));
        else v.f3 = 3'($urandom_range(0, 7));
        size = (v.f3[1:0] == 2'b00) ? 1 : (v.f3[1:0] == 2'b01) ? 2 : 4;
        lo = v.alu[1:0];
        mis = (kind != 0) && ((lo % size) != 0);
        trap = mis && TRAP;
        a = trap ? v.alu : v.alu - (lo % size);
        off = a % 4;
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        val = (v.rdata >> (8 * off)) & mask;
        if (!v.f3[2] && size < 4 && val[8 * size - 1]) val = val | ~mask;
        for (int b = 0; b < 4; b++) w[8 * b +: 8] = 8'(v.rs2 >> (8 * (b % size)));
        v.e_addr = a & 32'hFFFF_FFFC;
        v.e_be = 4'(((1 << size) - 1) << off);
        v.e_wdata = w;
        v.e_req = (kind != 0) && !trap;
        v.e_mis = trap;
        v.e_stall = !v.e_req ? 0 : (kind == 1) ? 3 + v.gw + v.rv : 2 + v.gw;
        if (kind == 1 && !trap) mdata_model = val;
        v.e_mdata = mdata_model;
        run_op(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010;
        ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
        //          pc          alu          rs2           rdata         rd    f3   rw mr mw m2r st gw rv stall req mis addr         wdata         mdata         be
        tbl[0] = '{32'h1000, 32'h1234, 32'h0,         32'h0,         5'd1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 32'h0,   32'h0,         32'h0,         4'b0000};
        tbl[1] = '{32'h1004, 32'h103,  32'h0,         32'h80AA_BBCC, 5'd2, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2, 0, 5, 1'b1, 1'b0, 32'h100, 32'h0,         32'hFFFF_FF80, 4'b0000};
        tbl[2] = '{32'h1008, 32'h202,  32'hDEAD_BEEF, 32'h0,         5'd0, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 2, 1'b1, 1'b0, 32'h200, 32'hBEEF_BEEF, 32'hFFFF_FF80, 4'b1100};
        tbl[3] = '{32'h100C, 32'h10,   32'h0,         32'h1234_8765, 5'd3, 3'b101, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 3, 6, 1'b1, 1'b0, 32'h10,  32'h0,         32'h0000_8765, 4'b0000};
        tbl[4] = '{32'h1010, 32'h7,    32'h0000_00A5, 32'h0,         5'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 3, 1'b1, 1'b0, 32'h4,   32'hA5A5_A5A5, 32'h0000_8765, 4'b1000};
        tbl[5] = '{32'h1014, 32'h22,   32'h0,         32'h9ABC_0000, 5'd6, 3'b001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 3, 1'b1, 1'b0, 32'h20,  32'h0,         32'hFFFF_9ABC, 4'b0000};
        tbl[6] = '{32'h1018, 32'h40,   32'h1122_3344, 32'h0,         5'd0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 2, 1'b1, 1'b0, 32'h40,  32'h1122_3344, 32'hFFFF_9ABC, 4'b1111};
        tbl[7] = '{32'h101C, 32'h41,   32'h0,         32'h0000_F700, 5'd7, 3'b100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 4, 1'b1, 1'b0, 32'h40,  32'h0,         32'h0000_00F7, 4'b0000};
        tbl[8] = '{32'h1020, 32'h80,   32'hFFFF_FFFF, 32'h55AA_55AA, 5'd8, 3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 3, 1'b1, 1'b0, 32'h80,  32'h0,         32'h55AA_55AA, 4'b0000};
`ifdef LSU_MISALIGN_TRAP_EN
        tbl[9] = '{32'h1024, 32'h6,    32'h0,         32'hCAFE_F00D, 5'd9, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1, 0, 1'b0, 1'b1, 32'h0,   32'h0,         32'h55AA_55AA, 4'b0000};
`else
        tbl[9] = '{32'h1024, 32'h6,    32'h0,         32'hCAFE_F00D, 5'd9, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1, 5, 1'b1, 1'b0, 32'h4,   32'h0,         32'hCAFE_F00D, 4'b0000};
`endif
        rst_n = 1'b0;
        drive_nop();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_cleared("reset");
        chk("reset_we", 32'(dmem_we), 32'd0);
        chk("reset_wdata", dmem_wdata, 32'd0);
        chk("reset_be", 32'(dmem_be), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NTBL; i++) run_op(tbl[i]);
        mdata_model = tbl[NTBL - 1].e_mdata;

        reset_mid(1'b0);
        reset_mid(1'b1);

        for (int i = 0; i < 150; i++) rand_op();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
